// File: rtl/qos_wrr.sv
// QoS buffer: one FIFO per virtual channel, drained by a weighted round-robin arbiter into a registered output.
// Latency: the head of a FIFO reaches out_data one edge after it is selected, so an empty system takes two edges from push to output.
// Backpressure: out_ready low holds the output word; a write to a full FIFO is dropped and flagged in error_full.
module qos_wrr #(
    parameter int NUM_VC      = 4,
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 8,
    parameter int WEIGHT_BITS = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enb,
    input  logic                          in_valid,
    input  logic [$clog2(NUM_VC)-1:0]     in_vc,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic [$clog2(DEPTH):0]        umbral_max,
    input  logic [$clog2(DEPTH):0]        umbral_min,
    input  logic [NUM_VC*WEIGHT_BITS-1:0] pesos,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_BITS-1:0]          out_data,
    output logic [$clog2(NUM_VC)-1:0]     out_vc,
    output logic [NUM_VC-1:0]             error_full,
    output logic [NUM_VC-1:0]             pausa,
    output logic [NUM_VC-1:0]             continuar,
    output logic                          idle
);
    localparam int VCW = $clog2(NUM_VC);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_BITS-1:0]   mem [NUM_VC][DEPTH];
    logic [AW-1:0]          wr_ptr [NUM_VC];
    logic [AW-1:0]          rd_ptr [NUM_VC];
    logic [CW-1:0]          cnt [NUM_VC];
    logic [CW-1:0]          cnt_nxt [NUM_VC];
    logic [NUM_VC-1:0]      nonempty, push_v, pop_v, pausa_nxt;
    logic [VCW-1:0]         cur, sel, cand;
    logic [WEIGHT_BITS-1:0] cred, w_sel, cred_nxt;
    logic                   reload, pop_en, push_ok, drop;

    assign push_ok = enb && in_valid && (cnt[in_vc] != FULL);
    assign drop    = enb && in_valid && (cnt[in_vc] == FULL);
    assign pop_en  = enb && (!out_valid || out_ready) && (|nonempty);
    assign idle    = ~(|nonempty) & ~out_valid;

    // Stay on cur while it has credit; otherwise the first non-empty VC after cur wins,
    // with cur itself checked last. The descending loop leaves the nearest candidate in sel.
    always_comb begin
        sel    = cur;
        cand   = cur;
        reload = 1'b0;
        if (!(nonempty[cur] && cred != '0)) begin
            reload = 1'b1;
            for (int i = NUM_VC; i >= 1; i--) begin
                cand = cur + VCW'(i);
                if (nonempty[cand]) sel = cand;
            end
        end
        w_sel    = pesos[sel*WEIGHT_BITS +: WEIGHT_BITS];
        cred_nxt = reload ? ((w_sel == '0) ? '0 : w_sel - 1'b1) : cred - 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            nonempty[i]  = (cnt[i] != '0);
            push_v[i]    = push_ok && (in_vc == VCW'(i));
            pop_v[i]     = pop_en && (sel == VCW'(i));
            cnt_nxt[i]   = cnt[i] + CW'(push_v[i]) - CW'(pop_v[i]);
            pausa_nxt[i] = pausa[i];
            if (cnt_nxt[i] >= umbral_max)      pausa_nxt[i] = 1'b1;
            else if (cnt_nxt[i] <= umbral_min) pausa_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[in_vc][wr_ptr[in_vc]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            cur        <= VCW'(NUM_VC - 1);
            cred       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_vc     <= '0;
            error_full <= '0;
            pausa      <= '0;
            continuar  <= '0;
        end else begin
            continuar <= '0;
            if (enb) begin
                for (int i = 0; i < NUM_VC; i++) begin
                    if (push_v[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop_v[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    cnt[i] <= cnt_nxt[i];
                end
                pausa     <= pausa_nxt;
                continuar <= pausa & ~pausa_nxt;
                if (drop) error_full[in_vc] <= 1'b1;
                if (pop_en) begin
                    out_valid <= 1'b1;
                    out_data  <= mem[sel][rd_ptr[sel]];
                    out_vc    <= sel;
                    cur       <= sel;
                    cred      <= cred_nxt;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_qos_wrr.sv
// Directed bench for qos_wrr: reset, single word, WRR order, overflow, hysteresis, backpressure/enable, async reset.
module tb_qos_wrr;
    logic        clk = 1'b0;
    logic        rst, enb, in_valid, out_ready;
    logic [1:0]  in_vc;
    logic [7:0]  in_data;
    logic [3:0]  umbral_max, umbral_min;
    logic [23:0] pesos;
    logic        out_valid, idle;
    logic [7:0]  out_data;
    logic [1:0]  out_vc;
    logic [3:0]  error_full, pausa, continuar;
    int total = 0;
    int bad   = 0;

    qos_wrr dut (
        .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data),
        .umbral_max(umbral_max), .umbral_min(umbral_min), .pesos(pesos), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_vc(out_vc), .error_full(error_full),
        .pausa(pausa), .continuar(continuar), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] vc, input logic [7:0] d);
        in_valid = 1'b1; in_vc = vc; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (out_vc !== 2'd0) begin bad++; $display("FAIL reset_out_vc got=%0d exp=0", out_vc); end
        total++; if ({error_full, pausa, continuar} !== 12'h000) begin bad++; $display("FAIL reset_status got=%h exp=000", {error_full, pausa, continuar}); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        push(2'd2, 8'hA5);
        total++; if (idle !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_k idle=%b out_valid=%b exp idle=0 out_valid=0", idle, out_valid); end
        tick();
        total++; if ({out_valid, out_data, out_vc} !== {1'b1, 8'hA5, 2'd2}) begin bad++; $display("FAIL single_out got v=%b d=%h vc=%0d exp v=1 d=a5 vc=2", out_valid, out_data, out_vc); end
        tick();
        total++; if (idle !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL single_idle idle=%b out_valid=%b exp idle=1 out_valid=0", idle, out_valid); end
    endtask

    task automatic test_wrr();
        int exp_vc[32] = '{0,0,0,1,1,2,3, 0,0,0,1,1,2,3, 0,0,1,1,2,3, 1,1,2,3, 2,3,2,3,2,3,2,3};
        int got[4] = '{0,0,0,0};
        int nout = 0;
        do_reset();
        pesos = {6'd1, 6'd1, 6'd2, 6'd3};
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < 8; k++) push(2'(v), 8'(v*16 + k));
        out_ready = 1'b1;
        for (int c = 0; c < 60 && !idle; c++) begin
            if (out_valid) begin
                if (nout < 32) begin
                    total++; if (out_vc !== 2'(exp_vc[nout])) begin bad++; $display("FAIL wrr_vc[%0d] got=%0d exp=%0d", nout, out_vc, exp_vc[nout]); end
                end
                total++; if (out_data !== 8'(out_vc*16 + got[out_vc])) begin bad++; $display("FAIL wrr_data[%0d] got=%h exp=%h", nout, out_data, 8'(out_vc*16 + got[out_vc])); end
                got[out_vc]++;
                nout++;
            end
            tick();
        end
        total++; if (nout != 32 || idle !== 1'b1) begin bad++; $display("FAIL wrr_count got=%0d idle=%b exp=32 idle=1", nout, idle); end
        pesos = {4{6'd1}};
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        push(2'd3, 8'hEE);
        tick();
        for (int k = 0; k < 8; k++) push(2'd1, 8'(8'h10 + k));
        total++; if (error_full !== 4'b0000) begin bad++; $display("FAIL ovf_before got=%b exp=0000", error_full); end
        push(2'd1, 8'h18);
        total++; if (error_full !== 4'b0010) begin bad++; $display("FAIL ovf_flag got=%b exp=0010", error_full); end
        tick();
        total++; if (error_full !== 4'b0010) begin bad++; $display("FAIL ovf_sticky got=%b exp=0010", error_full); end
        total++; if ({out_valid, out_data, out_vc} !== {1'b1, 8'hEE, 2'd3}) begin bad++; $display("FAIL ovf_head got v=%b d=%h vc=%0d exp v=1 d=ee vc=3", out_valid, out_data, out_vc); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if ({out_valid, out_data, out_vc} !== {1'b1, 8'(8'h10 + k), 2'd1}) begin bad++; $display("FAIL ovf_drain[%0d] got v=%b d=%h vc=%0d exp v=1 d=%h vc=1", k, out_valid, out_data, out_vc, 8'(8'h10 + k)); end
        end
        tick();
        total++; if (idle !== 1'b1 || error_full !== 4'b0010) begin bad++; $display("FAIL ovf_end idle=%b error_full=%b exp idle=1 error_full=0010", idle, error_full); end
    endtask

    task automatic test_hysteresis();
        do_reset();
        umbral_max = 4'd6; umbral_min = 4'd2;
        out_ready = 1'b0;
        push(2'd3, 8'hEE);
        tick();
        for (int k = 0; k < 5; k++) push(2'd0, 8'(k));
        total++; if (pausa !== 4'b0000) begin bad++; $display("FAIL hyst_at5 got=%b exp=0000", pausa); end
        push(2'd0, 8'h05);
        total++; if (pausa !== 4'b0001 || continuar !== 4'b0000) begin bad++; $display("FAIL hyst_at6 pausa=%b continuar=%b exp 0001 0000", pausa, continuar); end
        out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (pausa !== 4'b0001 || continuar !== 4'b0000) begin bad++; $display("FAIL hyst_at3 pausa=%b continuar=%b exp 0001 0000", pausa, continuar); end
        tick();
        total++; if (pausa !== 4'b0000 || continuar !== 4'b0001) begin bad++; $display("FAIL hyst_at2 pausa=%b continuar=%b exp 0000 0001", pausa, continuar); end
        tick();
        total++; if (continuar !== 4'b0000) begin bad++; $display("FAIL hyst_pulse got=%b exp=0000", continuar); end
        for (int c = 0; c < 20 && !idle; c++) tick();
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL hyst_drain idle=%b exp=1", idle); end
        umbral_max = 4'd15; umbral_min = 4'd0;
    endtask

    task automatic test_backpressure_enb();
        do_reset();
        out_ready = 1'b0;
        push(2'd2, 8'h31);
        push(2'd2, 8'h32);
        for (int c = 0; c < 5; c++) begin
            total++; if ({out_valid, out_data} !== {1'b1, 8'h31}) begin bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=31", c, out_valid, out_data); end
            tick();
        end
        enb = 1'b0; in_valid = 1'b1; in_vc = 2'd2; in_data = 8'h99; out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if ({out_valid, out_data, idle} !== {1'b1, 8'h31, 1'b0}) begin bad++; $display("FAIL enb_freeze got v=%b d=%h idle=%b exp v=1 d=31 idle=0", out_valid, out_data, idle); end
        enb = 1'b1; in_valid = 1'b0;
        tick();
        total++; if ({out_valid, out_data} !== {1'b1, 8'h32}) begin bad++; $display("FAIL enb_resume got v=%b d=%h exp v=1 d=32", out_valid, out_data); end
        tick();
        total++; if (idle !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL enb_nodrop idle=%b out_valid=%b exp idle=1 out_valid=0", idle, out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        push(2'd0, 8'h41);
        push(2'd1, 8'h42);
        push(2'd0, 8'h43);
        // make error_full non-zero so its asynchronous clear is visible
        for (int k = 0; k < 9; k++) push(2'd3, 8'h50);
        #2 rst = 1'b1;
        #1;
        total++; if ({out_valid, out_data, out_vc} !== {1'b0, 8'h00, 2'd0}) begin bad++; $display("FAIL arst_out got v=%b d=%h vc=%0d exp v=0 d=00 vc=0", out_valid, out_data, out_vc); end
        total++; if ({error_full, pausa, continuar, idle} !== {12'h000, 1'b1}) begin bad++; $display("FAIL arst_status got ef=%b p=%b c=%b idle=%b exp 0000 0000 0000 1", error_full, pausa, continuar, idle); end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        total++; if (idle !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_discard idle=%b out_valid=%b exp idle=1 out_valid=0", idle, out_valid); end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; in_valid = 1'b0; in_vc = 2'd0; in_data = 8'h00;
        umbral_max = 4'd15; umbral_min = 4'd0; pesos = {4{6'd1}}; out_ready = 1'b0;
        #3;
        test_reset();
        tick();
        rst = 1'b0;
        test_single();
        test_wrr();
        test_overflow();
        test_hysteresis();
        test_backpressure_enb();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qos_wrr.md
QOS_WRR -- requirements
Module: qos_wrr

Interface
REQ-001 Parameter NUM_VC, default 4, number of virtual channels (>=2, power of 2).
REQ-002 Parameter DATA_BITS, default 8, word width.
REQ-003 Parameter DEPTH, default 8, words per VC FIFO (power of 2); CW = $clog2(DEPTH)+1.
REQ-004 Parameter WEIGHT_BITS, default 6, width of each WRR weight.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enb  in  1  global enable; low freezes all state.
REQ-008 in_valid  in  1  write request.
REQ-009 in_vc  in  $clog2(NUM_VC)  target VC of write.
REQ-010 in_data  in  DATA_BITS  write data.
REQ-011 umbral_max / umbral_min  in  CW each  pause / resume thresholds, shared by all VCs.
REQ-012 pesos  in  NUM_VC*WEIGHT_BITS  weight of VC i at bits [i*WEIGHT_BITS +: WEIGHT_BITS].
REQ-013 out_ready  in  1  downstream accepts out_data.
REQ-014 out_valid / out_data / out_vc  out  1 / DATA_BITS / $clog2(NUM_VC)  registered output word and its source VC.
REQ-015 error_full, pausa, continuar  out  NUM_VC each  per-VC status, bit i = VC i.
REQ-016 idle  out  1  no data held anywhere.

Function
REQ-017 Write: when enb && in_valid, the word is pushed into FIFO in_vc if its count < DEPTH; otherwise the word is dropped.
REQ-018 A dropped write sets error_full[in_vc] on the following edge; the bit stays sticky until rst.
REQ-019 Pop condition: enb && (!out_valid || out_ready) && at least one FIFO non-empty; exactly one word is popped into the output register per pop edge.
REQ-020 If enb && out_valid && out_ready and no FIFO is non-empty, out_valid clears.
REQ-021 WRR state: current pointer cur and credit counter cred (WEIGHT_BITS wide).
REQ-022 At a pop: if FIFO cur is non-empty and cred>0, pop cur and decrement cred.
REQ-023 Otherwise search cyclically from cur+1 for the first non-empty VC v (cur itself is last in the search order); pop v, set cur=v, cred=max(w_v,1)-1.
REQ-024 A weight of 0 is treated as 1; weight changes take effect at the next reload only.
REQ-025 Latency: a word pushed at edge k into an empty system is on out_data with out_valid=1 after edge k+1.
REQ-026 Simultaneous push and pop on the same FIFO: both occur, count unchanged. The full check uses the pre-edge count, so a pop never frees space for a same-cycle push.
REQ-027 FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-028 pausa[i] is registered: it sets when next count >= umbral_max and clears when next count <= umbral_min; otherwise it holds (hysteresis).
REQ-029 continuar[i] is a one-cycle pulse on the edge where pausa[i] clears.
REQ-030 idle = all FIFOs empty && !out_valid (combinational).
REQ-031 out_data and out_vc hold their values while out_valid && !out_ready.
REQ-032 enb low: no push, no pop, and no change to cred, cur, pausa or error_full; continuar is forced to 0.

Reset
REQ-033 rst high, asynchronously: all counts and pointers = 0, cur = NUM_VC-1, cred = 0, out_valid = 0, out_data = 0, out_vc = 0, error_full = 0, pausa = 0, continuar = 0; idle = 1.
REQ-034 Reset mid-transfer discards all stored and in-flight words with no partial output.
REQ-035 Operation resumes on the first rising edge after rst falls.

Verification
REQ-036 Single word: push 0xA5 to VC2 at edge k with out_ready=1 -> out_valid=1, out_data=0xA5, out_vc=2 after edge k+1; idle=1 after edge k+2.
REQ-037 WRR: pesos={1,1,2,3} (VC3..VC0), 8 words preloaded in each VC, out_ready=1 -> out_vc sequence 0,0,0,1,1,2,3,0,0,0,...
REQ-038 Overflow: 9 pushes to VC1 with DEPTH=8, out_ready=0 -> 9th word dropped, error_full=4'b0010 and sticky; 8 words drain in order.
REQ-039 Hysteresis: umbral_max=6, umbral_min=2, fill VC0 to 6 -> pausa[0]=1; drain to 3 -> pausa still 1; drain to 2 -> pausa[0]=0 and continuar[0] pulses for exactly 1 cycle.
REQ-040 Backpressure/enb: out_ready=0 for 5 cycles holds out_data stable; enb=0 with in_valid=1 causes no count change and no pop.
REQ-041 Async reset: assert rst between edges with 3 words stored -> outputs reach REQ-033 values immediately, before the next edge; idle=1.
